// File: rtl/drp_arbiter.sv
// drp_arbiter: round-robin sharing of one transceiver DRP port among NUM_REQ requesters,
// with per-requester request latching and a watchdog for unacknowledged transactions.
module drp_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DRP_ADDR_WIDTH = 9,
  parameter int DRP_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                AXI_aclk,
  input  logic                                AXI_sreset,
  input  logic [NUM_REQ-1:0]                  req_en,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ*DRP_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DRP_DATA_WIDTH-1:0]   req_di,
  output logic [DRP_DATA_WIDTH-1:0]           req_do,
  output logic [NUM_REQ-1:0]                  req_rdy,
  output logic [NUM_REQ-1:0]                  req_err,
  output logic [NUM_REQ-1:0]                  grant,
  output logic                                busy,
  output logic                                drp_en,
  output logic                                drp_we,
  output logic [DRP_ADDR_WIDTH-1:0]           drp_addr,
  output logic [DRP_DATA_WIDTH-1:0]           drp_di,
  input  logic [DRP_DATA_WIDTH-1:0]           drp_do,
  input  logic                                drp_rdy
);
  localparam int AW = DRP_ADDR_WIDTH;
  localparam int DW = DRP_DATA_WIDTH;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   r_state;
  logic [NUM_REQ-1:0]           r_pend;
  logic [NUM_REQ-1:0]           r_we;
  logic [NUM_REQ-1:0][AW-1:0]   r_addr;
  logic [NUM_REQ-1:0][DW-1:0]   r_di;
  logic [PW-1:0]                r_ptr;
  logic [PW-1:0]                r_gidx;
  logic [15:0]                  r_cnt;
  logic [NUM_REQ-1:0]           r_grant;
  logic [NUM_REQ-1:0]           r_rdy;
  logic [NUM_REQ-1:0]           r_err;
  logic [DW-1:0]                r_do;
  logic                         r_drp_we;
  logic [AW-1:0]                r_drp_addr;
  logic [DW-1:0]                r_drp_di;
  logic [PW-1:0]                w_win;
  logic                         w_any;
  logic                         w_end;
  logic [NUM_REQ-1:0]           w_gmask;

  // Scan downward so the lowest offset from r_ptr wins.
  always_comb begin
    logic [PW-1:0] j;
    j     = '0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (r_pend[j]) w_win = j;
    end
  end

  assign w_any   = |r_pend;
  assign w_end   = drp_rdy || (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_gmask = NUM_REQ'(1) << r_gidx;

  always_ff @(posedge AXI_aclk or posedge AXI_sreset) begin
    if (AXI_sreset) begin
      r_state    <= S_IDLE;
      r_pend     <= '0;
      r_we       <= '0;
      r_addr     <= '0;
      r_di       <= '0;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_rdy      <= '0;
      r_err      <= '0;
      r_do       <= '0;
      r_drp_we   <= 1'b0;
      r_drp_addr <= '0;
      r_drp_di   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_en[i] && !r_pend[i]) begin
          r_we[i]   <= req_we[i];
          r_addr[i] <= req_addr[i*AW +: AW];
          r_di[i]   <= req_di[i*DW +: DW];
        end
      r_pend <= (r_pend | req_en) & ~((r_state == S_WAIT && w_end) ? w_gmask : '0);
      r_rdy  <= '0;
      r_err  <= '0;
      if (r_state == S_IDLE && w_any) begin
        r_state    <= S_ISSUE;
        r_gidx     <= w_win;
        r_grant    <= NUM_REQ'(1) << w_win;
        r_drp_we   <= r_we[w_win];
        r_drp_addr <= r_addr[w_win];
        r_drp_di   <= r_di[w_win];
        r_ptr      <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
      end else if (r_state == S_ISSUE) begin
        r_state  <= S_WAIT;
        r_cnt    <= '0;
        r_drp_we <= 1'b0;
      end else if (r_state == S_WAIT && w_end) begin
        r_state <= S_DONE;
        r_grant <= '0;
        r_rdy   <= w_gmask;
        r_err   <= drp_rdy ? '0 : w_gmask;
        r_do    <= drp_rdy ? drp_do : '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign req_do   = r_do;
  assign req_rdy  = r_rdy;
  assign req_err  = r_err;
  assign grant    = r_grant;
  assign busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign drp_en   = (r_state == S_ISSUE);
  assign drp_we   = r_drp_we;
  assign drp_addr = r_drp_addr;
  assign drp_di   = r_drp_di;
endmodule

// File: tb/tb_drp_arbiter.sv
// tb_drp_arbiter: directed scoreboard bench for drp_arbiter with a delayed-response DRP model.
module tb_drp_arbiter;
  localparam int N   = 2;
  localparam int AW  = 9;
  localparam int DW  = 16;
  localparam int TO  = 16;
  localparam int DLY = 3;

  typedef struct {int idx; logic [DW-1:0] d; logic err; int lat;} cmp_t;
  typedef struct {int idx; logic we; logic [AW-1:0] a; logic [DW-1:0] di;} iss_t;

  logic            AXI_aclk = 1'b0;
  logic            AXI_sreset = 1'b0;
  logic [N-1:0]    req_en = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_di = '0;
  logic [DW-1:0]   req_do;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    req_err;
  logic [N-1:0]    grant;
  logic            busy;
  logic            drp_en;
  logic            drp_we;
  logic [AW-1:0]   drp_addr;
  logic [DW-1:0]   drp_di;
  logic [DW-1:0]   drp_do = '0;
  logic            drp_rdy = 1'b0;

  cmp_t exp_q[$];
  iss_t iss_q[$];
  iss_t ie;
  cmp_t ce;
  int n_checks = 0, n_err = 0, cyc = 0, last_en = -1, n_rdy = 0, n_exp = 0, rsp_cnt = 0;
  bit mute = 1'b0, spurious = 1'b0, prev_en = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] rsp_val = '0;

  drp_arbiter #(.NUM_REQ(N), .DRP_ADDR_WIDTH(AW), .DRP_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .AXI_aclk(AXI_aclk), .AXI_sreset(AXI_sreset), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .req_di(req_di), .req_do(req_do), .req_rdy(req_rdy),
    .req_err(req_err), .grant(grant), .busy(busy), .drp_en(drp_en), .drp_we(drp_we),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do), .drp_rdy(drp_rdy)
  );

  always #5 AXI_aclk = ~AXI_aclk;

  function automatic logic [DW-1:0] model(logic [AW-1:0] a);
    return 16'hA59D ^ DW'(a);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0: normal completion, 1: timeout, 2: aborted by reset (no completion)
  task automatic drive(int i, logic we, logic [AW-1:0] a, logic [DW-1:0] d, int mode);
    iss_t s;
    cmp_t c;
    req_en[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_di[i*DW +: DW] = d;
    s.idx = i; s.we = we; s.a = a; s.di = d;
    iss_q.push_back(s);
    c.idx = i; c.d = (mode == 0) ? model(a) : 16'h0; c.err = (mode == 1); c.lat = (mode == 0) ? DLY + 1 : TO + 1;
    if (mode != 2) begin
      exp_q.push_back(c);
      n_exp++;
    end
  endtask

  task automatic wait_done(string tag, int max);
    int t = 0;
    while (t < max && !(exp_q.size() == 0 && iss_q.size() == 0 && !busy)) begin
      @(negedge AXI_aclk);
      req_en = '0;
      t++;
    end
    check(tag, (exp_q.size() == 0 && iss_q.size() == 0 && !busy), 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drp_en"}, drp_en, 0);
    check({tag, "_drp_we"}, drp_we, 0);
    check({tag, "_drp_addr"}, drp_addr, 0);
    check({tag, "_drp_di"}, drp_di, 0);
    check({tag, "_req_rdy"}, req_rdy, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_req_do"}, req_do, 0);
  endtask

  // DRP model: answers DLY cycles after drp_en unless muted
  always @(negedge AXI_aclk) begin
    drp_rdy = 1'b0;
    if (spurious) begin
      drp_rdy = 1'b1;
      spurious = 1'b0;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        drp_rdy = 1'b1;
        drp_do = rsp_val;
      end
    end
    if (drp_en && !mute) begin
      rsp_cnt = DLY;
      rsp_val = model(drp_addr);
    end
  end

  always @(negedge AXI_aclk) begin
    cyc++;
    if (!AXI_sreset) begin
      if (prev_en && !drp_en) begin
        check("drp_we_clear", drp_we, 0);
        check("drp_addr_hold", drp_addr, prev_addr);
      end
      if (drp_en) begin
        if (last_en >= 0) check("drp_en_gap", cyc - last_en >= 3, 1);
        last_en = cyc;
        prev_addr = drp_addr;
        check("issue_expected", iss_q.size() > 0, 1);
        if (iss_q.size() > 0) begin
          ie = iss_q.pop_front();
          check("grant", grant, 1 << ie.idx);
          check("drp_we", drp_we, ie.we);
          check("drp_addr", drp_addr, ie.a);
          check("drp_di", drp_di, ie.di);
        end
      end
      prev_en = drp_en;
      if (|req_rdy) begin
        n_rdy++;
        check("rdy_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          ce = exp_q.pop_front();
          check("req_rdy", req_rdy, 1 << ce.idx);
          check("req_err", req_err, ce.err ? (1 << ce.idx) : 0);
          check("req_do", req_do, ce.d);
          check("latency", cyc - last_en, ce.lat);
        end
      end
    end
  end

  initial begin
    int served, pushes, t;
    #1 AXI_sreset = 1'b1;
    @(negedge AXI_aclk);
    check_zero("reset");
    @(negedge AXI_aclk);
    AXI_sreset = 1'b0;
    // simultaneous write from 0 and read from 1, pointer at 0
    @(negedge AXI_aclk);
    drive(0, 1'b1, 9'h010, 16'h1234, 0);
    drive(1, 1'b0, 9'h020, 16'h0000, 0);
    @(negedge AXI_aclk);
    req_en = '0;
    wait_done("t2_drain", 100);
    // fairness: both keep re-requesting; issue queue order enforces alternation
    @(negedge AXI_aclk);
    drive(0, 1'b0, 9'h100, 16'h0, 0);
    drive(1, 1'b0, 9'h110, 16'h0, 0);
    served = 0;
    pushes = 2;
    for (int k = 0; k < 500 && served < 8; k++) begin
      @(negedge AXI_aclk);
      req_en = '0;
      for (int i = 0; i < N; i++)
        if (req_rdy[i]) begin
          served++;
          if (pushes < 8) begin
            drive(i, 1'b0, 9'(9'h100 + 16 * i + pushes), 16'h0, 0);
            pushes++;
          end
        end
    end
    check("t3_served", served, 8);
    wait_done("t3_drain", 100);
    // single read with latency checks
    @(negedge AXI_aclk);
    drive(0, 1'b0, 9'h05E, 16'h0, 0);
    @(negedge AXI_aclk);
    req_en = '0;
    check("t1_en_early", drp_en, 0);
    @(negedge AXI_aclk);
    check("t1_en", drp_en, 1);
    wait_done("t1_drain", 50);
    check("t1_req_do", req_do, 16'hA5C3);
    // duplicate requests while pending are ignored
    @(negedge AXI_aclk);
    drive(0, 1'b0, 9'h0C1, 16'h0, 0);
    @(negedge AXI_aclk);
    req_en[0] = 1'b1;
    req_addr[0 +: AW] = 9'h0C2;
    @(negedge AXI_aclk);
    req_en = '0;
    repeat (2) @(negedge AXI_aclk);
    req_en[0] = 1'b1;
    req_addr[0 +: AW] = 9'h0C3;
    @(negedge AXI_aclk);
    req_en = '0;
    wait_done("t6_drain", 50);
    repeat (3) @(negedge AXI_aclk);
    check("t6_rdy_count", n_rdy, n_exp);
    // timeout then a late drp_rdy
    mute = 1'b1;
    @(negedge AXI_aclk);
    drive(0, 1'b0, 9'h0AA, 16'h0, 1);
    @(negedge AXI_aclk);
    req_en = '0;
    wait_done("t4_drain", 60);
    mute = 1'b0;
    spurious = 1'b1;
    repeat (4) @(negedge AXI_aclk);
    check("t4_late_rdy", n_rdy, n_exp);
    check("t4_busy", busy, 0);
    // reset during WAIT
    mute = 1'b1;
    @(negedge AXI_aclk);
    drive(1, 1'b1, 9'h033, 16'h5A5A, 2);
    @(negedge AXI_aclk);
    req_en = '0;
    t = 0;
    while (t < 20 && !(busy && !drp_en)) begin
      @(negedge AXI_aclk);
      t++;
    end
    check("t5_in_wait", busy && !drp_en, 1);
    repeat (2) @(negedge AXI_aclk);
    #2 AXI_sreset = 1'b1;
    #1 check_zero("t5_reset");
    @(negedge AXI_aclk);
    AXI_sreset = 1'b0;
    mute = 1'b0;
    @(negedge AXI_aclk);
    drive(1, 1'b0, 9'h044, 16'h0, 0);
    @(negedge AXI_aclk);
    req_en = '0;
    wait_done("t5_drain", 50);
    repeat (3) @(negedge AXI_aclk);
    check("t5_rdy_count", n_rdy, n_exp);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
